// File: rtl/bn_seq_ctrl_if.sv
// Handshake/bus bundle between layer control, the BN unit, the output buffer and bn_seq_ctrl.
// master = sequencer side, slave = environment side.
interface bn_seq_ctrl_if #(
  parameter int BITWIDTH = 32,
  parameter int ADDR_W   = 8,
  parameter int CH_W     = 4
);
  logic                start;
  logic [ADDR_W-1:0]   in_addr;
  logic [CH_W-1:0]     ch_idx;
  logic                bn_start;
  logic                bn_finish;
  logic [BITWIDTH-1:0] bn_result;
  logic                out_valid;
  logic                out_ready;
  logic [BITWIDTH-1:0] out_data;
  logic [ADDR_W-1:0]   out_addr;
  logic                busy;
  logic                done;
  logic                error;

  modport master (
    input  start, bn_finish, bn_result, out_ready,
    output in_addr, ch_idx, bn_start, out_valid, out_data, out_addr, busy, done, error
  );

  modport slave (
    output start, bn_finish, bn_result, out_ready,
    input  in_addr, ch_idx, bn_start, out_valid, out_data, out_addr, busy, done, error
  );
endinterface

// File: rtl/bn_seq_ctrl.sv
// Sequencer for the multi-cycle BN2d datapath: walks CHANNELS x HEIGHT x WIDTH, issues each
// element to the BN unit, and forwards results over valid/ready. All outputs registered.
module bn_seq_ctrl #(
  parameter int BITWIDTH = 32,
  parameter int HEIGHT   = 1,
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 8,
  parameter int CH_W     = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic         clk,
  input  logic         rst,
  bn_seq_ctrl_if.master bus
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(CHANNELS * HEIGHT * WIDTH - 1);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(HEIGHT - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WRITE, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   col_q, col_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [BITWIDTH-1:0] out_data_q, out_data_d;
  logic                error_q, error_d;
  logic                bn_start_q, bn_start_d;
  logic                out_valid_q, out_valid_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    col_d      = col_q;
    row_d      = row_q;
    ch_d       = ch_q;
    wait_d     = wait_q;
    out_data_d = out_data_q;
    error_d    = error_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
          idx_d   = '0;
          col_d   = '0;
          row_d   = '0;
          ch_d    = '0;
          error_d = 1'b0;
        end
      end
      S_FETCH: state_d = S_ISSUE;
      S_ISSUE: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      S_WAIT: begin
        // A finish arriving on the timeout cycle still counts as success.
        if (bus.bn_finish) begin
          out_data_d = bus.bn_result;
          state_d    = S_WRITE;
        end else if (wait_q == LAST_WAIT) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (bus.out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            idx_d   = idx_q + 1'b1;
            if (col_q == LAST_COL) begin
              col_d = '0;
              if (row_q == LAST_ROW) begin
                row_d = '0;
                ch_d  = ch_q + 1'b1;
              end else begin
                row_d = row_q + 1'b1;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered from the next state so they line up with the state they describe.
    bn_start_d  = (state_d == S_ISSUE);
    out_valid_d = (state_d == S_WRITE);
    done_d      = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      ch_q        <= '0;
      wait_q      <= '0;
      out_data_q  <= '0;
      error_q     <= 1'b0;
      bn_start_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ch_q        <= ch_d;
      wait_q      <= wait_d;
      out_data_q  <= out_data_d;
      error_q     <= error_d;
      bn_start_q  <= bn_start_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_addr   = idx_q;
  assign bus.out_addr  = idx_q;
  assign bus.ch_idx    = ch_q;
  assign bus.bn_start  = bn_start_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_bn_seq_ctrl.sv
// Directed bench for bn_seq_ctrl with H=1, W=5, C=2, TIMEOUT=16 (10 elements per pass).
module tb_bn_seq_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   beats;
  int   dones;
  int   b0;
  int   d0;

  bn_seq_ctrl_if #(.BITWIDTH(32), .ADDR_W(8), .CH_W(4)) ifc ();

  bn_seq_ctrl #(
    .BITWIDTH(32), .HEIGHT(1), .WIDTH(5), .CHANNELS(2),
    .ADDR_W(8), .CH_W(4), .TIMEOUT(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Handshakes and done pulses observed mid-cycle, i.e. just before the edge that takes them.
  initial begin
    beats = 0;
    dones = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ifc.out_valid && ifc.out_ready) beats++;
        if (ifc.done) dones++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_issue();
    int n;
    n = 0;
    while (ifc.bn_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("bn_start_seen", 32'(ifc.bn_start), 32'd1);
  endtask

  // Runs one element from FETCH/ISSUE through the output handshake.
  task automatic do_elem(input int idx, input int ch, input logic [31:0] data,
                         input int fin_delay, input int stall, input bit poke);
    wait_issue();
    chk("in_addr", 32'(ifc.in_addr), 32'(idx));
    chk("ch_idx", 32'(ifc.ch_idx), 32'(ch));
    tick();
    ifc.start = poke;
    repeat (fin_delay - 1) tick();
    ifc.start     = 1'b0;
    ifc.bn_finish = 1'b1;
    ifc.bn_result = data;
    if (stall > 0) ifc.out_ready = 1'b0;
    tick();
    ifc.bn_finish = 1'b0;
    chk("out_valid", 32'(ifc.out_valid), 32'd1);
    chk("out_data", ifc.out_data, data);
    chk("out_addr", 32'(ifc.out_addr), 32'(idx));
    for (int k = 0; k < stall; k++) begin
      tick();
      chk("stall_valid", 32'(ifc.out_valid), 32'd1);
      chk("stall_data", ifc.out_data, data);
      chk("stall_addr", 32'(ifc.out_addr), 32'(idx));
      chk("stall_no_issue", 32'(ifc.bn_start), 32'd0);
    end
    ifc.out_ready = 1'b1;
    tick();
    chk("valid_drop", 32'(ifc.out_valid), 32'd0);
  endtask

  task automatic end_pass();
    chk("done_pulse", 32'(ifc.done), 32'd1);
    chk("busy_in_done", 32'(ifc.busy), 32'd1);
    tick();
    chk("done_clear", 32'(ifc.done), 32'd0);
    chk("busy_idle", 32'(ifc.busy), 32'd0);
  endtask

  task automatic kick();
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    chk("busy_fetch", 32'(ifc.busy), 32'd1);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    ifc.start     = 1'b0;
    ifc.bn_finish = 1'b0;
    ifc.bn_result = '0;
    ifc.out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_in_addr", 32'(ifc.in_addr), 32'd0);
    chk("rst_ch_idx", 32'(ifc.ch_idx), 32'd0);
    chk("rst_bn_start", 32'(ifc.bn_start), 32'd0);
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_out_data", ifc.out_data, 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_done", 32'(ifc.done), 32'd0);
    chk("rst_error", 32'(ifc.error), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // T1: plain pass, finish 2 cycles after bn_start
    b0 = beats; d0 = dones;
    kick();
    for (int i = 0; i < 10; i++) do_elem(i, i / 5, 32'h1000 + 32'(i), 2, 0, 1'b0);
    end_pass();
    chk("t1_beats", 32'(beats - b0), 32'd10);
    chk("t1_dones", 32'(dones - d0), 32'd1);
    chk("t1_error", 32'(ifc.error), 32'd0);

    // T2: backpressure on element 3
    b0 = beats; d0 = dones;
    kick();
    for (int i = 0; i < 10; i++) do_elem(i, i / 5, 32'hA000 + 32'(i), 2, (i == 3) ? 3 : 0, 1'b0);
    end_pass();
    chk("t2_beats", 32'(beats - b0), 32'd10);
    chk("t2_dones", 32'(dones - d0), 32'd1);

    // T3: start pulsed during WAIT of element 2
    b0 = beats; d0 = dones;
    kick();
    for (int i = 0; i < 10; i++) do_elem(i, i / 5, 32'h3000 + 32'(i), 2, 0, i == 2);
    end_pass();
    chk("t3_beats", 32'(beats - b0), 32'd10);
    chk("t3_dones", 32'(dones - d0), 32'd1);

    // T4: bn_finish never arrives
    b0 = beats; d0 = dones;
    kick();
    wait_issue();
    repeat (16) tick();
    chk("t4_no_err_yet", 32'(ifc.error), 32'd0);
    chk("t4_still_wait", 32'(ifc.done), 32'd0);
    tick();
    chk("t4_error", 32'(ifc.error), 32'd1);
    chk("t4_done", 32'(ifc.done), 32'd1);
    tick();
    chk("t4_idle", 32'(ifc.busy), 32'd0);
    chk("t4_sticky", 32'(ifc.error), 32'd1);
    chk("t4_beats", 32'(beats - b0), 32'd0);
    chk("t4_dones", 32'(dones - d0), 32'd1);

    // T5: next start clears error; reset during WAIT at idx 6
    kick();
    chk("t5_err_clr", 32'(ifc.error), 32'd0);
    for (int i = 0; i < 6; i++) do_elem(i, i / 5, 32'h5000 + 32'(i), 1, 0, 1'b0);
    d0 = dones;
    wait_issue();
    chk("t5_addr6", 32'(ifc.in_addr), 32'd6);
    chk("t5_ch6", 32'(ifc.ch_idx), 32'd1);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("t5_in_addr", 32'(ifc.in_addr), 32'd0);
    chk("t5_ch_idx", 32'(ifc.ch_idx), 32'd0);
    chk("t5_bn_start", 32'(ifc.bn_start), 32'd0);
    chk("t5_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("t5_out_data", ifc.out_data, 32'd0);
    chk("t5_out_addr", 32'(ifc.out_addr), 32'd0);
    chk("t5_busy", 32'(ifc.busy), 32'd0);
    chk("t5_done", 32'(ifc.done), 32'd0);
    chk("t5_error", 32'(ifc.error), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t5_no_done", 32'(dones - d0), 32'd0);

    // T6: stray bn_finish in IDLE and FETCH; signed result
    b0 = beats; d0 = dones;
    ifc.bn_finish = 1'b1;
    tick();
    chk("t6_idle_valid", 32'(ifc.out_valid), 32'd0);
    chk("t6_idle_busy", 32'(ifc.busy), 32'd0);
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    chk("t6_fetch_valid", 32'(ifc.out_valid), 32'd0);
    chk("t6_fetch_issue", 32'(ifc.bn_start), 32'd0);
    chk("t6_fetch_addr", 32'(ifc.in_addr), 32'd0);
    tick();
    ifc.bn_finish = 1'b0;
    chk("t6_issue_valid", 32'(ifc.out_valid), 32'd0);
    do_elem(0, 0, 32'hFFFF_FF85, 1, 0, 1'b0);
    for (int i = 1; i < 10; i++) do_elem(i, i / 5, 32'h6000 + 32'(i), 1, 0, 1'b0);
    end_pass();
    chk("t6_beats", 32'(beats - b0), 32'd10);
    chk("t6_dones", 32'(dones - d0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
